// File: rtl/flash_arbiter.sv
// Shares one QSPI flash reader between a CPU and an ADPCM audio requester.
// Audio wins ties, but only AUDIO_BURST_LIMIT times in a row while the CPU is waiting.
module flash_arbiter #(
  parameter int AUDIO_BURST_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_valid,
  input  logic [23:0] cpu_address,
  output logic        cpu_ready,
  output logic [31:0] cpu_data,
  input  logic        pcm_valid,
  input  logic [23:0] pcm_address,
  output logic        pcm_ready,
  output logic [31:0] pcm_data,
  output logic        flash_valid,
  output logic [23:0] flash_address,
  input  logic        flash_ready,
  input  logic [31:0] flash_data,
  output logic        busy
);

  localparam int SW = (AUDIO_BURST_LIMIT > 0) ? $clog2(AUDIO_BURST_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX  = SW'(AUDIO_BURST_LIMIT);
  localparam logic [SW-1:0] STREAK_ONE  = SW'(1);
  localparam logic [SW-1:0] STREAK_ZERO = SW'(0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t        state_q;
  logic [SW-1:0] pcm_streak_q;
  logic [SW-1:0] pcm_streak_d;
  logic          pcm_wins_s;
  logic          grant_pcm_q;
  logic          flash_valid_q;
  logic [23:0]   flash_address_q;
  logic          cpu_ready_q;
  logic [31:0]   cpu_data_q;
  logic          pcm_ready_q;
  logic [31:0]   pcm_data_q;
  logic          busy_q;

  // Winner of an IDLE arbitration and the streak value that grant leaves behind
  always_comb begin
    pcm_wins_s   = 1'b0;
    pcm_streak_d = STREAK_ZERO;
    if (pcm_valid && !(cpu_valid && (pcm_streak_q == STREAK_MAX))) begin
      pcm_wins_s = 1'b1;
      if (!cpu_valid) begin
        pcm_streak_d = STREAK_ZERO;
      end else if (pcm_streak_q == STREAK_MAX) begin
        pcm_streak_d = pcm_streak_q;
      end else begin
        pcm_streak_d = pcm_streak_q + STREAK_ONE;
      end
    end else begin
      pcm_wins_s   = 1'b0;
      pcm_streak_d = STREAK_ZERO;
    end
  end

  // Arbitration FSM; every output is a register so ready/data align with RESPOND
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      pcm_streak_q    <= STREAK_ZERO;
      grant_pcm_q     <= 1'b0;
      flash_valid_q   <= 1'b0;
      flash_address_q <= 24'd0;
      cpu_ready_q     <= 1'b0;
      cpu_data_q      <= 32'd0;
      pcm_ready_q     <= 1'b0;
      pcm_data_q      <= 32'd0;
      busy_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_valid || pcm_valid) begin
            state_q         <= READ;
            grant_pcm_q     <= pcm_wins_s;
            pcm_streak_q    <= pcm_streak_d;
            flash_valid_q   <= 1'b1;
            flash_address_q <= pcm_wins_s ? pcm_address : cpu_address;
            busy_q          <= 1'b1;
          end else begin
            flash_valid_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        READ: begin
          if (flash_ready) begin
            state_q         <= RESPOND;
            flash_valid_q   <= 1'b0;
            flash_address_q <= 24'd0;
            if (grant_pcm_q) begin
              pcm_ready_q <= 1'b1;
              pcm_data_q  <= flash_data;
            end else begin
              cpu_ready_q <= 1'b1;
              cpu_data_q  <= flash_data;
            end
          end else begin
            flash_valid_q <= 1'b1;
          end
        end
        // Requests are deliberately not sampled here; the next look is from IDLE
        RESPOND: begin
          state_q     <= IDLE;
          cpu_ready_q <= 1'b0;
          cpu_data_q  <= 32'd0;
          pcm_ready_q <= 1'b0;
          pcm_data_q  <= 32'd0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q         <= IDLE;
          flash_valid_q   <= 1'b0;
          flash_address_q <= 24'd0;
          cpu_ready_q     <= 1'b0;
          cpu_data_q      <= 32'd0;
          pcm_ready_q     <= 1'b0;
          pcm_data_q      <= 32'd0;
          busy_q          <= 1'b0;
        end
      endcase
    end
  end

  assign flash_valid   = flash_valid_q;
  assign flash_address = flash_address_q;
  assign cpu_ready     = cpu_ready_q;
  assign cpu_data      = cpu_data_q;
  assign pcm_ready     = pcm_ready_q;
  assign pcm_data      = pcm_data_q;
  assign busy          = busy_q;

endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 Parameter AUDIO_BURST_LIMIT, default 4: maximum number of consecutive PCM grants while a CPU request is pending.
REQ-002 clk  input  1  single clock for all logic (2x domain).
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cpu_valid  input  1  CPU read request; held high until cpu_ready.
REQ-005 cpu_address  input  24  CPU flash byte address; stable while cpu_valid is high.
REQ-006 cpu_ready  output  1  one-cycle completion pulse to CPU.
REQ-007 cpu_data  output  32  CPU read data; valid only while cpu_ready is high.
REQ-008 pcm_valid  input  1  audio (ADPCM) read request; held high until pcm_ready.
REQ-009 pcm_address  input  24  audio flash byte address; stable while pcm_valid is high.
REQ-010 pcm_ready  output  1  one-cycle completion pulse to the audio requester.
REQ-011 pcm_data  output  32  audio read data; valid only while pcm_ready is high.
REQ-012 flash_valid  output  1  request to the shared QSPI flash reader.
REQ-013 flash_address  output  24  address presented to the flash reader.
REQ-014 flash_ready  input  1  one-cycle flash reader completion pulse.
REQ-015 flash_data  input  32  flash reader data, valid with flash_ready.
REQ-016 busy  output  1  high in every state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, READ, RESPOND.
REQ-018 In IDLE, with neither valid high, the block SHALL stay in IDLE and drive flash_valid low.
REQ-019 In IDLE, with any valid high at cycle N, the block SHALL latch the winner and its address, enter READ, and assert flash_valid with flash_address from cycle N+1.
REQ-020 Priority: pcm wins when both are valid, unless pcm_streak equals AUDIO_BURST_LIMIT, in which case cpu wins.
REQ-021 pcm_streak SHALL increment, saturating at AUDIO_BURST_LIMIT, on a PCM grant with cpu_valid high, and SHALL clear to 0 on any CPU grant or on a PCM grant with cpu_valid low.
REQ-022 pcm_streak width SHALL be clog2(AUDIO_BURST_LIMIT+1).
REQ-023 In READ, flash_valid and flash_address SHALL hold until flash_ready is sampled high at cycle M.
REQ-024 On that flash_ready, the block SHALL register flash_data and enter RESPOND; flash_valid SHALL be low from M+1.
REQ-025 In RESPOND (cycle M+1), the block SHALL pulse exactly the granted requester's ready for one cycle, drive its data, then return to IDLE.
REQ-026 Valid inputs SHALL NOT be sampled in RESPOND, so a requester whose valid is still high during its ready cycle is never re-granted spuriously.
REQ-027 The next flash_valid after a completion SHALL rise no earlier than M+3.
REQ-028 flash_ready while not in READ SHALL be ignored.
REQ-029 A requester dropping valid mid-transaction is a protocol violation; the transaction SHALL still complete and the ready pulse SHALL still issue.
REQ-030 cpu_data and pcm_data SHALL be 0 whenever their ready is low.
REQ-031 cpu_ready and pcm_ready SHALL never be high in the same cycle.

Reset
REQ-032 While reset_n is low: state IDLE, pcm_streak 0, and all outputs 0 (flash_valid, flash_address, cpu_ready, cpu_data, pcm_ready, pcm_data, busy).
REQ-033 Reset asserted mid-READ SHALL abandon the flash transaction with no ready pulse.
REQ-034 Arbitration SHALL resume from IDLE on the first clock edge after reset_n deasserts.

Verification
REQ-035 Single CPU read: cpu_valid at N, address 0x100000; flash_ready with data 0xDEADBEEF at N+5 -> flash_valid high N+1..N+5 with address 0x100000, cpu_ready and cpu_data=0xDEADBEEF at N+6 only, busy low at N+7.
REQ-036 Simultaneous requests: cpu_valid and pcm_valid both high at N -> PCM served first, CPU granted in the IDLE cycle following the PCM RESPOND.
REQ-037 Starvation limit: CPU held pending while PCM re-requests continuously -> exactly 4 PCM grants, then a CPU grant, then the streak resets.
REQ-038 Stray flash_ready pulsed in IDLE and in RESPOND -> no state change and no ready outputs.
REQ-039 reset_n pulsed low mid-READ -> all outputs 0 immediately; no cpu_ready or pcm_ready for the abandoned request; a fresh request after release completes normally.
